// File: rtl/elevator_request_latch.sv
// Call-button front end for the 3-floor elevator: synchronise, debounce, latch requests,
// clear them on service and lock each floor out for a while after it has been served.
module elevator_request_latch #(
   parameter int NUM_FLOORS      = 3,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLDOFF_CYCLES  = 8,
   parameter int CNT_W           = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] btn_raw,
   input  logic [1:0]            current_floor,
   input  logic                  door_open,
   output logic [NUM_FLOORS-1:0] req,
   output logic [1:0]            req_count,
   output logic [NUM_FLOORS-1:0] press_evt
);

   typedef enum logic [1:0] {IDLE, PENDING, LOCKOUT} state_t;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

   logic [NUM_FLOORS-1:0] sync1, sync2, deb;
   logic [NUM_FLOORS-1:0] rise, service, req_nxt, evt_nxt;
   logic [CNT_W-1:0]      cnt  [NUM_FLOORS];
   logic [CNT_W-1:0]      hold [NUM_FLOORS];
   state_t                state [NUM_FLOORS];

   function automatic logic [1:0] popcount(input logic [NUM_FLOORS-1:0] v);
      logic [1:0] n;
      n = '0;
      for (int i = 0; i < NUM_FLOORS; i++) n = n + 2'(v[i]);
      return n;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         for (int i = 0; i < NUM_FLOORS; i++) cnt[i] <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         for (int i = 0; i < NUM_FLOORS; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // rise is the debounced 0->1 flip happening on this very edge
   always_comb begin
      rise    = '0;
      service = '0;
      req_nxt = '0;
      evt_nxt = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         rise[i]    = ~deb[i] & sync2[i] & (cnt[i] == DEB_LAST);
         service[i] = door_open & (current_floor == 2'(i));
         case (state[i])
            IDLE: begin
               req_nxt[i] = rise[i] & ~service[i];
               evt_nxt[i] = rise[i] & ~service[i];
            end
            PENDING: req_nxt[i] = ~service[i];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req       <= '0;
         req_count <= '0;
         press_evt <= '0;
         for (int i = 0; i < NUM_FLOORS; i++) begin
            state[i] <= IDLE;
            hold[i]  <= '0;
         end
      end else begin
         req       <= req_nxt;
         req_count <= popcount(req_nxt);
         press_evt <= evt_nxt;
         for (int i = 0; i < NUM_FLOORS; i++) begin
            case (state[i])
               IDLE: begin
                  // a press landing on the service edge is swallowed by the lockout
                  if (rise[i] && service[i]) begin
                     state[i] <= LOCKOUT;
                     hold[i]  <= HOLD_LAST;
                  end else if (rise[i]) begin
                     state[i] <= PENDING;
                  end
               end
               PENDING: begin
                  if (service[i]) begin
                     state[i] <= LOCKOUT;
                     hold[i]  <= HOLD_LAST;
                  end
               end
               LOCKOUT: begin
                  if (hold[i] == '0) state[i] <= IDLE;
                  else               hold[i]  <= hold[i] - CNT_W'(1);
               end
               default: state[i] <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_elevator_request_latch.sv
// Bench for elevator_request_latch: directed scenarios plus random traffic against a
// behavioural model based on sample windows and "edges since service" arithmetic.
module tb_elevator_request_latch;
   localparam int N    = 3;
   localparam int DEB  = 4;
   localparam int HOLD = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] btn_raw = '0;
   logic [1:0] current_floor = '0;
   logic       door_open = 1'b0;
   logic [2:0] req;
   logic [1:0] req_count;
   logic [2:0] press_evt;

   int total = 0;
   int bad   = 0;

   elevator_request_latch #(
      .NUM_FLOORS(N), .DEBOUNCE_CYCLES(DEB), .HOLDOFF_CYCLES(HOLD), .CNT_W(4)
   ) dut (
      .clk(clk), .reset(reset), .btn_raw(btn_raw), .current_floor(current_floor),
      .door_open(door_open), .req(req), .req_count(req_count), .press_evt(press_evt)
   );

   always #5 clk = ~clk;

   // model state
   bit s1 [N];
   bit s2 [N];
   bit deb_m [N];
   bit pend [N];
   bit evt_m [N];
   int svc_edge [N];
   bit hist [N][$];
   int k;

   task automatic model_reset();
      k = 0;
      for (int i = 0; i < N; i++) begin
         s1[i] = 0; s2[i] = 0; deb_m[i] = 0; pend[i] = 0; evt_m[i] = 0;
         svc_edge[i] = -100000;
         hist[i].delete();
      end
   endtask

   // advance the model across one clock edge using the currently driven inputs
   task automatic model_edge();
      bit rise, svc;
      int mism;
      k++;
      for (int i = 0; i < N; i++) begin
         hist[i].push_back(s2[i]);
         if (hist[i].size() > DEB) void'(hist[i].pop_front());
         mism = 0;
         foreach (hist[i][j]) if (hist[i][j] != deb_m[i]) mism++;
         rise = 0;
         if (hist[i].size() == DEB && mism == DEB) begin
            deb_m[i] = ~deb_m[i];
            rise = deb_m[i];
         end
         s2[i] = s1[i];
         s1[i] = btn_raw[i];
         svc = door_open && (current_floor == 2'(i));
         evt_m[i] = 0;
         if (k - svc_edge[i] <= HOLD) begin
            // locked out: presses and service both ignored
         end else if (pend[i]) begin
            if (svc) begin pend[i] = 0; svc_edge[i] = k; end
         end else if (rise) begin
            if (svc) svc_edge[i] = k;
            else begin pend[i] = 1; evt_m[i] = 1; end
         end
      end
   endtask

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic compare();
      logic [2:0] er, ee;
      int c;
      c = 0;
      for (int i = 0; i < N; i++) begin
         er[i] = pend[i];
         ee[i] = evt_m[i];
         c += int'(pend[i]);
      end
      chk("model_req", req, er);
      chk("model_count", {1'b0, req_count}, 3'(c));
      chk("model_evt", press_evt, ee);
   endtask

   task automatic cycle(input logic [2:0] b, input logic [1:0] cf, input logic d);
      btn_raw = b; current_floor = cf; door_open = d;
      model_edge();
      @(posedge clk); #1;
      compare();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      compare();
      chk("reset_req_async", req, 3'b000);
      chk("reset_evt_async", press_evt, 3'b000);
      @(posedge clk); #1;
      compare();
      reset = 1'b0;
   endtask

   task automatic repeat_cycle(input int n, input logic [2:0] b);
      for (int j = 0; j < n; j++) cycle(b, 2'd0, 1'b0);
   endtask

   initial begin
      logic [2:0] rb;
      int evt1;
      bit saw_req1;

      @(posedge clk); @(posedge clk); #1;
      do_reset();
      chk("reset_count", {1'b0, req_count}, 3'b000);

      // clean press on floor 2
      repeat_cycle(5, 3'b100);
      chk("clean_before_edge6", req, 3'b000);
      cycle(3'b100, 2'd0, 1'b0);
      chk("clean_req_edge6", req, 3'b100);
      chk("clean_evt_edge6", press_evt, 3'b100);
      chk("clean_count", {1'b0, req_count}, 3'd1);
      cycle(3'b100, 2'd0, 1'b0);
      chk("clean_evt_one_cycle", press_evt, 3'b000);
      repeat_cycle(10, 3'b000);
      chk("clean_req_held", req, 3'b100);

      // bounce on floor 1 then a solid hold
      evt1 = 0; saw_req1 = 0;
      for (int j = 0; j < 5; j++) begin
         cycle(3'b010, 2'd0, 1'b0);
         if (press_evt[1]) evt1++;
         if (req[1]) saw_req1 = 1;
         cycle(3'b000, 2'd0, 1'b0);
         if (press_evt[1]) evt1++;
         if (req[1]) saw_req1 = 1;
      end
      repeat_cycle(3, 3'b000);
      chk("bounce_no_req", {2'b00, saw_req1}, 3'b000);
      for (int j = 0; j < 10; j++) begin
         cycle(3'b010, 2'd0, 1'b0);
         if (press_evt[1]) evt1++;
      end
      chk("bounce_one_evt", 3'(evt1), 3'd1);
      chk("bounce_req", req, 3'b110);

      // service floor 2, press again inside the lockout, then after it
      repeat_cycle(8, 3'b000);
      cycle(3'b000, 2'd2, 1'b1);
      chk("service_req", req, 3'b010);
      chk("service_count", {1'b0, req_count}, 3'd1);
      repeat_cycle(6, 3'b100);
      chk("lockout_press_dropped", req, 3'b010);
      repeat_cycle(8, 3'b000);
      repeat_cycle(8, 3'b100);
      chk("repress_after_lockout", req, 3'b110);

      // press and service of floor 0 on the same edge
      repeat_cycle(5, 3'b001);
      cycle(3'b001, 2'd0, 1'b1);
      chk("simul_req0", req & 3'b001, 3'b000);
      chk("simul_evt0", press_evt & 3'b001, 3'b000);

      // lockout boundary on floor 0: rise at service+8 dropped, at service+9 accepted
      for (int off = 8; off <= 9; off++) begin
         repeat_cycle(8, 3'b000);
         repeat_cycle(8, 3'b001);
         repeat_cycle(8, 3'b000);
         cycle(3'b000, 2'd0, 1'b1);
         repeat_cycle(off - 6, 3'b000);
         repeat_cycle(8, 3'b001);
         chk("lockout_boundary", req & 3'b001, (off == 9) ? 3'b001 : 3'b000);
      end

      // all floors, then an invalid floor service
      for (int f = 0; f < 3; f++) cycle(3'b000, 2'(f), 1'b1);
      repeat_cycle(10, 3'b000);
      repeat_cycle(5, 3'b111);
      cycle(3'b111, 2'd0, 1'b0);
      chk("all_req", req, 3'b111);
      chk("all_count", {1'b0, req_count}, 3'd3);
      chk("all_evt", press_evt, 3'b111);
      cycle(3'b111, 2'd0, 1'b0);
      chk("all_evt_one_cycle", press_evt, 3'b000);
      cycle(3'b111, 2'd3, 1'b1);
      chk("invalid_floor", req, 3'b111);

      // reset in the middle of debouncing floor 0
      repeat_cycle(3, 3'b001);
      do_reset();
      repeat_cycle(5, 3'b001);
      chk("post_reset_before_edge6", req, 3'b000);
      cycle(3'b001, 2'd0, 1'b0);
      chk("post_reset_req", req, 3'b001);
      chk("post_reset_evt", press_evt, 3'b001);

      // random traffic
      rb = 3'b000;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(7) == 0) rb[i] = ~rb[i];
         if ($urandom_range(599) == 0) begin
            btn_raw = rb;
            do_reset();
         end else begin
            cycle(rb, 2'($urandom_range(3)), ($urandom_range(5) == 0));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
